// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions.
// Used by the single-cycle main decoder and the multicycle control FSM.
// Contents:
//   - opcode constants
//   - multicycle control state encoding
//   - ALU op, ALU B-source and PC-source select codes
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13
  } ctrl_state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the MIPS32 core.
// It steps the shared datapath through fetch, decode, execute, memory and
// writeback. Memory may stretch any access with mem_ready wait states.
//
// Ports:
//   clk, rst_n        core clock, async active-low reset
//   op                IR[31:26]
//   mem_ready         memory finishes the current access this cycle
//   mem_req/mem_write/iord                       memory control
//   ir_write/pc_write/branch/pc_src              IR and PC control
//   reg_dst/mem_to_reg/reg_write                 register file control
//   alu_src_a/alu_src_b/alu_op                   ALU control
//   instr_done        last cycle of the current instruction
//   illegal_op        unsupported opcode decoded
//   state_dbg         current state code
//
// state   | meaning
// --------+---------------------------------------------
// IDLE    | out of reset; every output is 0
// FETCH   | read the instruction at PC, compute PC+4
// DECODE  | read registers, precompute the branch target
// MEMADR  | compute the LW/SW effective address
// MEMRD   | LW data read
// MEMWB   | LW writes MDR to rt
// MEMWR   | SW data write
// EXECUTE | R-type ALU operation
// ALUWB   | R-type writes ALUOut to rd
// BRANCH  | BEQ compare, then PC load if zero
// ADDIEX  | ADDI add
// ADDIWB  | ADDI writes ALUOut to rt
// JUMP    | load the jump target into PC
// ILLEGAL | flag the bad opcode for one cycle, no writes
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  ctrl_state_t r_state;
  ctrl_state_t w_next;

  // The outputs are decoded straight from the state register, so an async
  // reset drops mem_req and mem_write at once. An aborted write is not retried.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  assign state_dbg = r_state;

  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    pc_src     = PCSRC_ALU;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (r_state)
      S_IDLE: w_next = S_FETCH;

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR and PC+4 are committed only in the cycle that memory accepts.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end

      S_DECODE: begin
        alu_src_b = SRCB_IMMSH2;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_ILLEGAL;
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (op == OP_LW)      w_next = S_MEMRD;
        else if (op == OP_SW) w_next = S_MEMWR;
        else                  w_next = S_ILLEGAL;
      end

      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end

      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end

      S_MEMWR: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) w_next = S_FETCH;
      end

      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        w_next    = S_ALUWB;
      end

      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = PCSRC_ALUOUT;
        branch     = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end

      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end

      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end

      S_ILLEGAL: begin
        illegal_op = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end

      // Codes 14 and 15 cannot be reached. They recover to IDLE.
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl.
// Each cycle the driver applies op/mem_ready and pushes the expected packed
// output vector. The monitor pops it 2 ns later and compares it with the DUT.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_write, branch;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       instr_done, illegal_op;
  logic [3:0] state_dbg;

  logic [21:0] w_obs;
  logic [21:0] sb[$];
  int          n_vec = 0;
  int          n_err = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .instr_done(instr_done), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  assign w_obs = {mem_req, mem_write, iord, ir_write, pc_write, branch,
                  reg_dst, mem_to_reg, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_src, instr_done, illegal_op, state_dbg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // The expected outputs for each state, written out from the control table.
  function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic mr);
    logic mrq, mw, io, irw, pcw, br, rd, m2r, rw, sa, dn, il;
    logic [1:0] sbv, ao, ps;
    {mrq, mw, io, irw, pcw, br, rd, m2r, rw, sa, dn, il} = '0;
    sbv = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      4'd1:  begin mrq = 1; sbv = 2'b01; irw = mr; pcw = mr; end
      4'd2:  sbv = 2'b11;
      4'd3,
      4'd10: begin sa = 1; sbv = 2'b10; end
      4'd4:  begin mrq = 1; io = 1; end
      4'd5:  begin m2r = 1; rw = 1; dn = 1; end
      4'd6:  begin mrq = 1; io = 1; mw = 1; dn = mr; end
      4'd7:  begin sa = 1; ao = 2'b10; end
      4'd8:  begin rd = 1; rw = 1; dn = 1; end
      4'd9:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; dn = 1; end
      4'd11: begin rw = 1; dn = 1; end
      4'd12: begin ps = 2'b10; pcw = 1; dn = 1; end
      4'd13: begin il = 1; dn = 1; end
      default: ;
    endcase
    return {mrq, mw, io, irw, pcw, br, rd, m2r, rw, sa, sbv, ao, ps, dn, il, st};
  endfunction

  task automatic drive(input logic [3:0] st, input logic mr, input logic [5:0] opv);
    @(negedge clk);
    op        = opv;
    mem_ready = mr;
    sb.push_back(exp_vec(st, mr));
  endtask

  // After reset is released the FSM spends one cycle in IDLE, then goes to FETCH.
  task automatic release_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    op        = OP_RTYPE;
    mem_ready = 1'b1;
    sb.push_back(exp_vec(4'd0, 1'b1));
  endtask

  always @(negedge clk) begin
    logic [21:0] e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("st%0d", e[3:0]), {10'd0, w_obs}, {10'd0, e});
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    op        = OP_RTYPE;
    mem_ready = 1'b1;
    #3;
    chk("reset_outputs", {10'd0, w_obs}, 32'd0);
    @(posedge clk);
    #1;
    chk("reset_hold_state", {28'd0, state_dbg}, 32'd0);

    release_reset();
    // R-type
    drive(1, 1, OP_RTYPE); drive(2, 1, OP_RTYPE); drive(7, 1, OP_RTYPE); drive(8, 1, OP_RTYPE);
    // LW: two FETCH waits, one MEMRD wait
    drive(1, 0, OP_LW); drive(1, 0, OP_LW); drive(1, 1, OP_LW); drive(2, 1, OP_LW);
    drive(3, 1, OP_LW); drive(4, 0, OP_LW); drive(4, 1, OP_LW); drive(5, 1, OP_LW);
    // SW: three MEMWR waits
    drive(1, 1, OP_SW); drive(2, 1, OP_SW); drive(3, 1, OP_SW);
    drive(6, 0, OP_SW); drive(6, 0, OP_SW); drive(6, 0, OP_SW); drive(6, 1, OP_SW);
    // BEQ, with mem_ready low where it must be ignored
    drive(1, 1, OP_BEQ); drive(2, 0, OP_BEQ); drive(9, 0, OP_BEQ);
    // J
    drive(1, 1, OP_J); drive(2, 1, OP_J); drive(12, 0, OP_J);
    // ADDI
    drive(1, 1, OP_ADDI); drive(2, 1, OP_ADDI); drive(10, 0, OP_ADDI); drive(11, 1, OP_ADDI);
    // Illegal opcode
    drive(1, 1, 6'h3F); drive(2, 1, 6'h3F); drive(13, 1, 6'h3F);
    // R-type with mem_ready low in EXECUTE/ALUWB (ignored)
    drive(1, 1, OP_RTYPE); drive(2, 0, OP_RTYPE); drive(7, 0, OP_RTYPE); drive(8, 0, OP_RTYPE);

    // SW aborted by reset while in MEMWR
    drive(1, 1, OP_SW); drive(2, 1, OP_SW); drive(3, 1, OP_SW); drive(6, 0, OP_SW);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
    chk("rst_state",     {28'd0, state_dbg}, 32'd0);
    release_reset();
    drive(1, 1, OP_J); drive(2, 1, OP_J); drive(12, 1, OP_J);
    drive(1, 0, OP_J);

    @(negedge clk);
    #4;
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control FSM for the MIPS32 core: sequences the shared datapath (single-port instruction/data memory, one ALU, IR, register file, PC) through fetch, decode, execute, memory and writeback steps. Supports the same instruction set as the single-cycle main decoder: R-type, LW, SW, BEQ, ADDI and J. Adds a memory-ready handshake so memory may insert wait states. Sits between the IR opcode field and the datapath mux/enable inputs.

## Interface
- No parameters.
- clk  in  1  core clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  opcode, IR[31:26]
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access active
- mem_write  out  1  write strobe; valid only with mem_req
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR
- pc_write  out  1  unconditional PC load
- branch  out  1  conditional PC load; datapath PC enable = pc_write | (branch & zero)
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  last cycle of the current instruction
- illegal_op  out  1  unsupported opcode decoded
- state_dbg  out  4  current state encoding

## Operation
- States (encoding): IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXECUTE 7, ALUWB 8, BRANCH 9, ADDIEX 10, ADDIWB 11, JUMP 12, ILLEGAL 13. Codes 14–15 are unreachable and go to IDLE.
- Transitions:
  - IDLE→FETCH.
  - FETCH holds until mem_ready, then →DECODE.
  - DECODE on op: 100011/101011→MEMADR, 000000→EXECUTE, 000100→BRANCH, 001000→ADDIEX, 000010→JUMP, any other→ILLEGAL.
  - MEMADR: LW→MEMRD, SW→MEMWR.
  - MEMRD holds until mem_ready, then →MEMWB.
  - MEMWR holds until mem_ready, then →FETCH.
  - EXECUTE→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP and ILLEGAL all →FETCH.
- Outputs per state (unlisted outputs = 0):
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=pc_write=mem_ready.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - MEMADR, ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD: mem_req=1, iord=1.
  - MEMWR: mem_req=1, iord=1, mem_write=1.
  - MEMWB: mem_to_reg=1, reg_write=1, reg_dst=0.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10.
  - ALUWB: reg_dst=1, reg_write=1.
  - ADDIWB: reg_dst=0, reg_write=1.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1.
  - JUMP: pc_src=10, pc_write=1.
  - ILLEGAL: illegal_op=1; no writes.
- instr_done=1 in: MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, ILLEGAL, and MEMWR when mem_ready.
- op is sampled only in DECODE and MEMADR; the datapath holds the IR stable until the next FETCH.

## Timing
- Outputs are decoded from state; only ir_write and pc_write in FETCH, and instr_done in MEMWR, also depend on mem_ready.
- Cycles per instruction with zero wait states: R 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3, illegal 3. Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- Reset: state goes to IDLE immediately on rst_n low. All outputs are 0 and state_dbg=0 while in IDLE. The first rising edge after rst_n goes high enters FETCH.
- Reset mid-access aborts it: mem_req and mem_write drop asynchronously, and the partial write is not retried.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.

## Structure
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, shared with the single-cycle decoder;
  - state typedef ctrl_state_t with the encodings above;
  - ALU op, alu_src_b and pc_src constants.
- Single module: one state register plus one combinational next-state/output block. No sub-module.

## Test plan
- Reset, then R-type (op=000000) with mem_ready held 1 → state_dbg sequence 1,2,7,8,1; reg_write=1 and reg_dst=1 only in ALUWB; instr_done pulses once.
- LW with mem_ready low for 2 cycles in FETCH and 1 cycle in MEMRD → 8 cycles total; ir_write and pc_write high only in the accepting FETCH cycle; mem_to_reg=1 in MEMWB.
- SW with mem_ready low 3 cycles in MEMWR → mem_write and iord held at 1 for 4 cycles; instr_done only in the mem_ready cycle; then FETCH.
- BEQ → branch=1, alu_op=01, pc_src=01 in state 9; J → pc_write=1, pc_src=10 in state 12; both return to FETCH after 3 cycles.
- op=111111 → ILLEGAL for one cycle with illegal_op=1 and no reg_write, pc_write or mem_write; then FETCH.
- rst_n pulsed low during MEMWR → mem_write drops asynchronously; state_dbg=0; FETCH on the first edge after release.
